// File: rtl/alu_pkg.sv
// Shared types, opcode constants and the combinational execute function for the ALU command issuer.
package alu_pkg;

  localparam int unsigned OPERAND_W = 4;
  localparam int unsigned OPCODE_W  = 3;
  localparam int unsigned CMD_W     = 2 * OPERAND_W + OPCODE_W;

  localparam logic [OPCODE_W-1:0] OP_ADD = 3'b001;
  localparam logic [OPCODE_W-1:0] OP_SUB = 3'b010;
  localparam logic [OPCODE_W-1:0] OP_AND = 3'b011;
  localparam logic [OPCODE_W-1:0] OP_OR  = 3'b100;
  localparam logic [OPCODE_W-1:0] OP_NOT = 3'b101;

  typedef struct packed {
    logic [OPCODE_W-1:0]  f;
    logic [OPERAND_W-1:0] a;
    logic [OPERAND_W-1:0] b;
  } cmd_t;

  typedef struct packed {
    logic [OPERAND_W-1:0] y;
    logic                 carry;
    logic                 err;
  } res_t;

  typedef enum logic {
    StEmpty,
    StHold
  } out_state_e;

  // Sub uses a 5-bit difference so bit 4 is the borrow (set iff a < b).
  function automatic res_t alu_exec(cmd_t c);
    logic [OPERAND_W:0] wide;
    res_t               r;
    r    = '0;
    wide = '0;
    case (c.f)
      OP_ADD: begin
        wide    = {1'b0, c.a} + {1'b0, c.b};
        r.y     = wide[OPERAND_W-1:0];
        r.carry = wide[OPERAND_W];
      end
      OP_SUB: begin
        wide    = {1'b0, c.a} - {1'b0, c.b};
        r.y     = wide[OPERAND_W-1:0];
        r.carry = wide[OPERAND_W];
      end
      OP_AND:  r.y = c.a & c.b;
      OP_OR:   r.y = c.a | c.b;
      OP_NOT:  r.y = ~c.a;
      default: r.err = 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO; pointers carry one extra wrap bit to tell full from empty.
module alu_cmd_fifo
  import alu_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = CMD_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] PtrOne = 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wptr_q, wptr_d;
  logic [AW:0]      rptr_q, rptr_d;
  logic             do_push, do_pop;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

  // A push while full is dropped even if a pop happens on the same edge.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign rdata = mem_q[rptr_q[AW-1:0]];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (do_push) wptr_d = wptr_q + PtrOne;
    if (do_pop)  rptr_d = rptr_q + PtrOne;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/alu_cmd_issuer.sv
// Queues ALU commands, executes them in order and presents one registered result at a time.
module alu_cmd_issuer
  import alu_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_a,
  input  logic [3:0] cmd_b,
  input  logic [2:0] cmd_f,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [3:0] res_y,
  output logic       res_carry,
  output logic       res_zero,
  output logic       res_err,
  output logic [7:0] op_count
);

  out_state_e state_q, state_d;
  cmd_t       push_cmd, head_cmd;
  res_t       res_q;
  logic [7:0] op_count_q;
  logic       fifo_full, fifo_empty;
  logic       push, pop;

  assign push_cmd = '{f: cmd_f, a: cmd_a, b: cmd_b};

  // Hold off the producer during reset even though the FIFO looks empty.
  assign cmd_ready = rst_n && !fifo_full;
  assign push      = cmd_valid && cmd_ready;

  alu_cmd_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(CMD_W)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (push),
    .wdata(push_cmd),
    .pop  (pop),
    .rdata(head_cmd),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    unique case (state_q)
      StEmpty: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = StHold;
        end
      end
      StHold: begin
        if (res_ready) begin
          if (!fifo_empty) pop = 1'b1;
          else             state_d = StEmpty;
        end
      end
      default: state_d = StEmpty;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StEmpty;
      res_q      <= '0;
      op_count_q <= '0;
    end else begin
      state_q <= state_d;
      if (pop) res_q <= alu_exec(head_cmd);
      if (res_valid && res_ready) op_count_q <= op_count_q + 8'd1;
    end
  end

  assign res_valid = (state_q == StHold);
  assign res_y     = res_q.y;
  assign res_carry = res_q.carry;
  assign res_err   = res_q.err;
  assign res_zero  = (res_q.y == '0);
  assign op_count  = op_count_q;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Directed bench for alu_cmd_issuer: reset, opcode results, backpressure, mid-stream reset, wrap.
module tb_alu_cmd_issuer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_a;
  logic [3:0] cmd_b;
  logic [2:0] cmd_f;
  logic       res_valid;
  logic       res_ready;
  logic [3:0] res_y;
  logic       res_carry;
  logic       res_zero;
  logic       res_err;
  logic [7:0] op_count;

  int tests = 0;
  int fails = 0;

  alu_cmd_issuer #(.DEPTH(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_a    (cmd_a),
    .cmd_b    (cmd_b),
    .cmd_f    (cmd_f),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_y    (res_y),
    .res_carry(res_carry),
    .res_zero (res_zero),
    .res_err  (res_err),
    .op_count (op_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] req);
    tests++;
    assert (obs === req) else begin
      fails++;
      $error("FAIL %s: observed %0d required %0d", tag, obs, req);
    end
  endtask

  task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [2:0] f);
    cmd_a     = a;
    cmd_b     = b;
    cmd_f     = f;
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
  endtask

  // One command into an idle block with res_ready=1, then check the held result.
  task automatic run1(input string tag, input logic [3:0] a, input logic [3:0] b,
                      input logic [2:0] f, input logic [3:0] ey, input logic ec,
                      input logic ez, input logic ee);
    send(a, b, f);
    step();
    chk({tag, "_valid"}, res_valid, 1);
    chk({tag, "_y"}, res_y, ey);
    chk({tag, "_carry"}, res_carry, ec);
    chk({tag, "_zero"}, res_zero, ez);
    chk({tag, "_err"}, res_err, ee);
    step();
    chk({tag, "_done"}, res_valid, 0);
  endtask

  logic [3:0] ey;

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_a     = '0;
    cmd_b     = '0;
    cmd_f     = '0;
    res_ready = 1'b0;
    step();
    step();
    chk("rst_valid", res_valid, 0);
    chk("rst_y", res_y, 0);
    chk("rst_carry", res_carry, 0);
    chk("rst_zero", res_zero, 1);
    chk("rst_err", res_err, 0);
    chk("rst_count", op_count, 0);
    chk("rst_ready", cmd_ready, 0);
    rst_n = 1'b1;
    #1;
    chk("rel_ready", cmd_ready, 1);

    // Single add: visible two edges after acceptance.
    res_ready = 1'b1;
    send(4'd9, 4'd8, 3'b001);
    chk("add_lat", res_valid, 0);
    step();
    chk("add_valid", res_valid, 1);
    chk("add_y", res_y, 1);
    chk("add_carry", res_carry, 1);
    chk("add_zero", res_zero, 0);
    chk("add_err", res_err, 0);
    chk("add_cnt0", op_count, 0);
    step();
    chk("add_done", res_valid, 0);
    chk("add_cnt1", op_count, 1);

    run1("sub_borrow", 4'd3, 4'd5, 3'b010, 4'd14, 1'b1, 1'b0, 1'b0);
    run1("sub_eq", 4'd5, 4'd5, 3'b010, 4'd0, 1'b0, 1'b1, 1'b0);
    run1("inv000", 4'd15, 4'd15, 3'b000, 4'd0, 1'b0, 1'b1, 1'b1);
    run1("inv110", 4'd15, 4'd15, 3'b110, 4'd0, 1'b0, 1'b1, 1'b1);
    run1("inv111", 4'd15, 4'd15, 3'b111, 4'd0, 1'b0, 1'b1, 1'b1);
    run1("nota", 4'd10, 4'd0, 3'b101, 4'd5, 1'b0, 1'b0, 1'b0);
    run1("and", 4'd12, 4'd10, 3'b011, 4'd8, 1'b0, 1'b0, 1'b0);
    run1("or", 4'd12, 4'd10, 3'b100, 4'd14, 1'b0, 1'b0, 1'b0);
    run1("add_nc", 4'd3, 4'd4, 3'b001, 4'd7, 1'b0, 1'b0, 1'b0);
    chk("cnt10", op_count, 10);

    // Backpressure: 5 pushes fill 4 FIFO entries plus the held result.
    res_ready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      cmd_a     = 4'(k);
      cmd_b     = 4'd1;
      cmd_f     = 3'b001;
      cmd_valid = 1'b1;
      step();
    end
    cmd_valid = 1'b0;
    chk("bp_full", cmd_ready, 0);
    chk("bp_valid", res_valid, 1);
    chk("bp_y1", res_y, 2);
    step();
    chk("bp_stable", res_y, 2);
    chk("bp_nopop", cmd_ready, 0);
    // Offer a sixth command on the same edge as the first pop; it must be refused.
    cmd_a     = 4'd7;
    cmd_b     = 4'd7;
    cmd_f     = 3'b001;
    cmd_valid = 1'b1;
    res_ready = 1'b1;
    step();
    cmd_valid = 1'b0;
    chk("bp_y2", res_y, 3);
    chk("bp_ready", cmd_ready, 1);
    step();
    chk("bp_y3", res_y, 4);
    step();
    chk("bp_y4", res_y, 5);
    step();
    chk("bp_y5", res_y, 6);
    step();
    chk("bp_refused", res_valid, 0);
    chk("cnt15", op_count, 15);

    // Reset with one held and three queued results.
    res_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cmd_a     = 4'(k + 8);
      cmd_b     = 4'd2;
      cmd_f     = 3'b100;
      cmd_valid = 1'b1;
      step();
    end
    cmd_valid = 1'b0;
    chk("mr_valid", res_valid, 1);
    rst_n = 1'b0;
    step();
    chk("mr_rvalid", res_valid, 0);
    chk("mr_cnt", op_count, 0);
    chk("mr_y", res_y, 0);
    chk("mr_ready0", cmd_ready, 0);
    rst_n = 1'b1;
    #1;
    chk("mr_ready1", cmd_ready, 1);
    res_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("mr_stale", res_valid, 0);
    end
    chk("mr_cnt2", op_count, 0);

    // 260 back-to-back and-ops across many pointer wraps.
    cmd_valid = 1'b1;
    for (int i = 0; i < 260; i++) begin
      cmd_a = 4'(i);
      cmd_b = 4'(i * 7 + 3);
      cmd_f = 3'b011;
      step();
      chk("wr_ready", cmd_ready, 1);
      if (i >= 1) begin
        ey = 4'(i - 1) & 4'((i - 1) * 7 + 3);
        chk("wr_valid", res_valid, 1);
        chk("wr_y", res_y, ey);
      end
    end
    cmd_valid = 1'b0;
    step();
    ey = 4'(259) & 4'(259 * 7 + 3);
    chk("wr_last", res_y, ey);
    step();
    chk("wr_empty", res_valid, 0);
    chk("wr_cnt", op_count, 4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
